// File: rtl/ahbl_slave_mem_if.sv
// AHB-Lite responder-side bundle: master drives address/control/write data,
// the slave returns ready, response, read data and its error counter.
interface ahbl_slave_mem_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADYIN;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [7:0]  ERR_COUNT;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
    input  HWDATA, HREADYIN,
    output HREADYOUT, HRESP, HRDATA, ERR_COUNT
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
    output HWDATA, HREADYIN,
    input  HREADYOUT, HRESP, HRDATA, ERR_COUNT
  );
endinterface

// File: rtl/ahbl_slave_mem.sv
// AHB-Lite slave RAM: byte-lane writes, programmable wait states, two-cycle
// ERROR response for illegal accesses and a saturating error counter.
module ahbl_slave_mem #(
  parameter int MEM_AW      = 12,
  parameter int WAIT_STATES = 0,
  parameter int READ_ONLY   = 0
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ahbl_slave_mem_if.slave bus
);

  localparam int WA    = MEM_AW - 2;
  localparam int WORDS = 2 ** WA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state_reg;
  logic [MEM_AW-1:0] addr_reg;
  logic              write_reg;
  logic [2:0]        size_reg;
  logic              dp_valid_reg;
  logic [3:0]        wait_cnt_reg;
  logic              ready_reg;
  logic              resp_reg;
  logic [7:0]        err_count_reg;

  logic              can_accept;
  logic              accept;
  logic              addr_err;
  logic              size_err;
  logic              align_err;
  logic              ro_err;
  logic              req_err;
  logic              commit;
  logic [3:0]        be;
  logic [WA-1:0]     waddr;
  logic [WA-1:0]     raddr;
  logic [31:0]       rd_word;
  logic              unused_ok;

  assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0]};

  // A new address phase is only taken when this slave is not stalling the bus.
  assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
  assign accept     = can_accept && bus.HSEL && bus.HREADYIN && bus.HTRANS[1];

  assign addr_err  = |bus.HADDR[31:MEM_AW];
  assign size_err  = bus.HSIZE > 3'd2;
  assign align_err = ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                     ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
  assign ro_err    = (READ_ONLY != 0) && bus.HWRITE;
  assign req_err   = addr_err || size_err || align_err || ro_err;

  // An OKAY data phase sitting in IDLE is the completing cycle.
  assign commit = (state_reg == ST_IDLE) && dp_valid_reg && write_reg;

  always_comb begin
    be = 4'b0000;
    case (size_reg)
      3'd0:    be[addr_reg[1:0]] = 1'b1;
      3'd1:    be = addr_reg[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign waddr = addr_reg[MEM_AW-1:2];
  assign raddr = bus.HADDR[MEM_AW-1:2];

  // One RAM per byte lane; the read is captured at address acceptance and
  // forwards a write committing on the same edge to the same word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] ram [WORDS];
      logic [7:0] rd_reg;

      always_ff @(posedge HCLK) begin
        if (commit && be[gi]) begin
          ram[waddr] <= bus.HWDATA[gi*8 +: 8];
        end
        if (accept) begin
          if (commit && be[gi] && (waddr == raddr)) begin
            rd_reg <= bus.HWDATA[gi*8 +: 8];
          end else begin
            rd_reg <= ram[raddr];
          end
        end
      end

      assign rd_word[gi*8 +: 8] = rd_reg;
    end
  endgenerate

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      write_reg     <= 1'b0;
      size_reg      <= 3'd0;
      dp_valid_reg  <= 1'b0;
      wait_cnt_reg  <= 4'd0;
      ready_reg     <= 1'b1;
      resp_reg      <= 1'b0;
      err_count_reg <= 8'd0;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        ST_ERR1: begin
          state_reg <= ST_ERR2;
          ready_reg <= 1'b1;
          resp_reg  <= 1'b1;
        end
        default: begin
          if ((state_reg == ST_ERR2) && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
          end
          if (accept) begin
            addr_reg  <= bus.HADDR[MEM_AW-1:0];
            write_reg <= bus.HWRITE;
            size_reg  <= bus.HSIZE;
            if (req_err) begin
              state_reg    <= ST_ERR1;
              ready_reg    <= 1'b0;
              resp_reg     <= 1'b1;
              dp_valid_reg <= 1'b0;
            end else if (WAIT_STATES > 0) begin
              state_reg    <= ST_WAIT;
              wait_cnt_reg <= 4'(WAIT_STATES - 1);
              ready_reg    <= 1'b0;
              resp_reg     <= 1'b0;
              dp_valid_reg <= 1'b1;
            end else begin
              state_reg    <= ST_IDLE;
              ready_reg    <= 1'b1;
              resp_reg     <= 1'b0;
              dp_valid_reg <= 1'b1;
            end
          end else begin
            state_reg    <= ST_IDLE;
            ready_reg    <= 1'b1;
            resp_reg     <= 1'b0;
            dp_valid_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.HREADYOUT = ready_reg;
  assign bus.HRESP     = resp_reg;
  assign bus.HRDATA    = (dp_valid_reg && !write_reg) ? rd_word : 32'h0;
  assign bus.ERR_COUNT = err_count_reg;

endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Randomised scoreboard bench for ahbl_slave_mem: three instances (no wait,
// three waits, read-only) share one master; a monitor checks each data phase.
module tb_ahbl_slave_mem;

  logic        clk = 1'b0;
  logic [2:0]  rst;
  int          cur;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  logic [2:0]  ready_a;
  logic [2:0]  resp_a;
  logic [31:0] rdata_a [3];
  logic [7:0]  ecnt_a [3];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      ahbl_slave_mem_if bus ();
      assign bus.HSEL      = hsel && (cur == gi);
      assign bus.HADDR     = haddr;
      assign bus.HTRANS    = htrans;
      assign bus.HWRITE    = hwrite;
      assign bus.HSIZE     = hsize;
      assign bus.HBURST    = 3'b000;
      assign bus.HPROT     = 4'b0011;
      assign bus.HMASTLOCK = 1'b0;
      assign bus.HWDATA    = hwdata;
      assign bus.HREADYIN  = bus.HREADYOUT;

      ahbl_slave_mem #(
        .MEM_AW      (12),
        .WAIT_STATES ((gi == 1) ? 3 : 0),
        .READ_ONLY   ((gi == 2) ? 1 : 0)
      ) u_dut (
        .HCLK   (clk),
        .HRESET (rst[gi]),
        .bus    (bus)
      );

      assign ready_a[gi] = bus.HREADYOUT;
      assign resp_a[gi]  = bus.HRESP;
      assign rdata_a[gi] = bus.HRDATA;
      assign ecnt_a[gi]  = bus.ERR_COUNT;
    end
  endgenerate

  typedef struct {
    bit          err;
    bit          rd;
    int          waits;
    logic [31:0] data;
    logic [31:0] mask;
    logic [31:0] addr;
  } exp_t;

  exp_t       q[$];
  logic [7:0] ref_mem [3][4096];
  bit         known [3][4096];
  int         ecnt_model [3];
  int         n_checks = 0;
  int         n_pass = 0;
  bit         dp_active = 1'b0;
  int         dp_waits = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s (dut%0d): got 0x%0h required 0x%0h", name, cur, act, req);
  endtask

  // Reference model: applies the access rules at the moment a transfer is accepted.
  task automatic model_accept(input logic [31:0] a, input bit w, input logic [2:0] sz,
                              input logic [31:0] wd);
    exp_t e;
    int   base;
    bit   sel;
    base   = int'({a[11:2], 2'b00});
    e.err  = (a[31:12] != 0) || (sz > 3'd2) || ((sz == 3'd1) && a[0]) ||
             ((sz == 3'd2) && (a[1:0] != 2'b00)) || ((cur == 2) && w);
    e.rd   = !w;
    e.waits = e.err ? 1 : ((cur == 1) ? 3 : 0);
    e.data = 32'h0;
    e.mask = 32'h0;
    e.addr = a;
    if (e.err) begin
      if (ecnt_model[cur] < 255) ecnt_model[cur]++;
    end else if (w) begin
      for (int l = 0; l < 4; l++) begin
        if (sz == 3'd0) sel = (l == int'(a[1:0]));
        else if (sz == 3'd1) sel = ((l / 2) == int'(a[1]));
        else sel = 1'b1;
        if (sel) begin
          ref_mem[cur][base + l] = wd[8*l +: 8];
          known[cur][base + l]   = 1'b1;
        end
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        e.data[8*l +: 8] = ref_mem[cur][base + l];
        if (known[cur][base + l]) e.mask[8*l +: 8] = 8'hFF;
      end
    end
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the address phase is taken.
  task automatic xfer(input logic [31:0] a, input bit w, input logic [2:0] sz,
                      input logic [31:0] wd);
    bit rdy;
    int guard;
    haddr  = a;
    htrans = 2'b10;
    hwrite = w;
    hsize  = sz;
    guard  = 0;
    rdy    = 1'b0;
    while (!rdy && guard < 50) begin
      @(negedge clk);
      rdy = ready_a[cur];
      @(posedge clk);
      guard++;
    end
    if (!rdy) begin
      n_checks++;
      $display("FAIL accept_timeout (dut%0d): HREADYOUT stayed 0, required 1", cur);
    end else begin
      model_accept(a, w, sz, wd);
    end
    #1;
    htrans = 2'b00;
    hwdata = wd;
  endtask

  task automatic idle_cycles(input int n, input logic [1:0] tr);
    htrans = tr;
    hwrite = 1'($urandom_range(0, 1));
    haddr  = 32'($urandom_range(0, 127));
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    htrans = 2'b00;
  endtask

  task automatic drain();
    int g;
    g = 0;
    htrans = 2'b00;
    while ((q.size() > 0 || dp_active) && g < 100) begin
      @(posedge clk);
      g++;
    end
    if (g >= 100) begin
      n_checks++;
      $display("FAIL drain_timeout (dut%0d): %0d responses outstanding, required 0", cur, q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ecnt();
    chk("err_count", ecnt_a[cur], ecnt_model[cur]);
  endtask

  task automatic rand_xfer(input int max_addr);
    int          kind;
    logic [2:0]  sz;
    logic [31:0] a;
    bit          w;
    kind = $urandom_range(0, 9);
    sz   = 3'($urandom_range(0, 2));
    a    = 32'($urandom_range(0, max_addr));
    w    = 1'($urandom_range(0, 1));
    a    = a & ~((32'd1 << sz) - 32'd1);
    if (kind == 0) a = a | ($urandom & 32'hFFFFF000) | 32'h0000_1000;
    if (kind == 1) sz = 3'($urandom_range(3, 7));
    if (kind == 2 && sz != 3'd0) a = a | 32'd1;
    xfer(a, w, sz, $urandom);
    if ($urandom_range(0, 5) == 0) idle_cycles(1, ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00);
  endtask

  task automatic prefill(input int words);
    for (int i = 0; i < words; i++) xfer(32'(i * 4), 1'b1, 3'd2, $urandom);
    drain();
  endtask

  // Monitor: evaluates each cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (i != cur && !rst[i]) begin
        chk("unselected_idle", {ready_a[i], resp_a[i], rdata_a[i]}, {1'b1, 1'b0, 32'h0});
      end
    end
    if (rst[cur]) begin
      dp_active = 1'b0;
      q.delete();
    end else begin
      if (dp_active) begin
        if (!ready_a[cur]) begin
          dp_waits++;
          if (q.size() > 0) chk("resp_in_wait", resp_a[cur], q[0].err);
        end else begin
          if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_response (dut%0d): data phase with empty scoreboard", cur);
          end else begin
            e = q.pop_front();
            chk("wait_cycles", dp_waits, e.waits);
            chk("resp", resp_a[cur], e.err);
            if (e.rd && !e.err) begin
              if (e.mask != 0) chk("rdata", rdata_a[cur] & e.mask, e.data & e.mask);
            end else begin
              chk("rdata_zero", rdata_a[cur], 32'h0);
            end
            $display("dut%0d %s @%08h resp=%0d waits=%0d rdata=%08h", cur,
                     e.rd ? "RD" : "WR", e.addr, resp_a[cur], dp_waits, rdata_a[cur]);
          end
          dp_active = 1'b0;
        end
      end else begin
        chk("idle_bus", {ready_a[cur], resp_a[cur], rdata_a[cur]}, {1'b1, 1'b0, 32'h0});
      end
      if (hsel && htrans[1] && ready_a[cur]) begin
        dp_active = 1'b1;
        dp_waits  = 0;
      end
    end
  end

  initial begin
    logic [7:0] sv [4];
    bit         skn [4];
    rst    = 3'b111;
    cur    = 0;
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hwdata = 32'h0;
    for (int i = 0; i < 3; i++) ecnt_model[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready", ready_a[i], 1'b1);
      chk("reset_resp", resp_a[i], 1'b0);
      chk("reset_rdata", rdata_a[i], 32'h0);
      chk("reset_err_count", ecnt_a[i], 8'd0);
    end
    rst  = 3'b000;
    hsel = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait instance: directed lane tests, errors, idle/busy, random traffic.
    cur = 0;
    prefill(32);
    xfer(32'h010, 1'b1, 3'd2, 32'hDEADBEEF);
    xfer(32'h010, 1'b0, 3'd2, 32'h0);
    xfer(32'h011, 1'b1, 3'd0, 32'h0000AA00);
    xfer(32'h010, 1'b0, 3'd2, 32'h0);
    xfer(32'h012, 1'b1, 3'd1, 32'h12340000);
    xfer(32'h010, 1'b0, 3'd2, 32'h0);
    drain();
    xfer(32'h1000, 1'b0, 3'd2, 32'h0);
    xfer(32'h001, 1'b0, 3'd1, 32'h0);
    drain();
    chk_ecnt();
    hwdata = 32'hFFFFFFFF;
    idle_cycles(3, 2'b00);
    idle_cycles(3, 2'b01);
    xfer(32'h010, 1'b0, 3'd2, 32'h0);
    xfer(32'h000, 1'b0, 3'd2, 32'h0);
    drain();
    for (int i = 0; i < 150; i++) rand_xfer(127);
    drain();
    chk_ecnt();

    // Three-wait instance.
    cur = 1;
    prefill(32);
    xfer(32'h010, 1'b0, 3'd2, 32'h0);
    xfer(32'h014, 1'b0, 3'd2, 32'h0);
    xfer(32'h018, 1'b0, 3'd2, 32'h0);
    drain();
    for (int i = 0; i < 60; i++) rand_xfer(127);
    xfer(32'h1000, 1'b0, 3'd2, 32'h0);
    drain();
    chk_ecnt();

    // Asynchronous reset in the middle of a write's wait states.
    for (int l = 0; l < 4; l++) begin
      sv[l]  = ref_mem[1][32 + l];
      skn[l] = known[1][32 + l];
    end
    xfer(32'h020, 1'b1, 3'd2, 32'hCAFEF00D);
    @(posedge clk);
    #2;
    rst[1] = 1'b1;
    #1;
    chk("async_reset_ready", ready_a[1], 1'b1);
    chk("async_reset_resp", resp_a[1], 1'b0);
    chk("async_reset_err_count", ecnt_a[1], 8'd0);
    for (int l = 0; l < 4; l++) begin
      ref_mem[1][32 + l] = sv[l];
      known[1][32 + l]   = skn[l];
    end
    ecnt_model[1] = 0;
    #4;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;
    xfer(32'h020, 1'b0, 3'd2, 32'h0);
    drain();
    chk_ecnt();

    // Read-only instance: write errors and counter saturation.
    cur = 2;
    xfer(32'h000, 1'b1, 3'd2, 32'h11111111);
    xfer(32'h000, 1'b0, 3'd2, 32'h0);
    drain();
    chk_ecnt();
    for (int i = 0; i < 259; i++) xfer(32'($urandom_range(0, 255)) & ~32'd3, 1'b1, 3'd2, $urandom);
    drain();
    chk_ecnt();
    xfer(32'h000, 1'b0, 3'd2, 32'h0);
    drain();
    chk_ecnt();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
